// File: rtl/testing_cpu_oci_pkg.sv
// Shared types and constants for the OCI data-trace atom packer.
// Word geometry, FSM state encoding and a slot-insert helper.
`timescale 1ns/1ps
package testing_cpu_oci_pkg;

   localparam int ATOM_W = 2;
   localparam int SLOTS  = 15;
   localparam int DCT_W  = ATOM_W * SLOTS;
   localparam int CNT_W  = 4;

   localparam logic [CNT_W-1:0] LAST_SLOT  = CNT_W'(SLOTS - 1);
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(SLOTS);

   typedef enum logic [1:0] {
      FILL  = 2'd0,
      FLUSH = 2'd1,
      DRAIN = 2'd2,
      ENDED = 2'd3
   } dct_state_t;

   // Returns word with the atom written into the given slot; slot 0 sits in the LSBs.
   function automatic logic [DCT_W-1:0] put_atom(input logic [DCT_W-1:0]  word,
                                                 input logic [CNT_W-1:0]  slot,
                                                 input logic [ATOM_W-1:0] code);
      logic [DCT_W-1:0] res;
      res = word;
      for (int k = 0; k < SLOTS; k++) begin
         if (slot == CNT_W'(k)) res[ATOM_W*k +: ATOM_W] = code;
      end
      return res;
   endfunction

endpackage

// File: rtl/testing_cpu_oci_dct_packer.sv
// Packs 2-bit trace atoms into 15-slot words for the OCI trace consumer and
// flushes the partial word on end-of-test before raising test_has_ended.
`timescale 1ns/1ps
module testing_cpu_oci_dct_packer
   import testing_cpu_oci_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              atm_valid,
   input  logic [ATOM_W-1:0] atm_code,
   output logic              atm_ready,
   input  logic              test_ending_in,
   input  logic              dct_ready,
   output logic              dct_valid,
   output logic [DCT_W-1:0]  dct_buffer,
   output logic [CNT_W-1:0]  dct_count,
   output logic              test_ending,
   output logic              test_has_ended
);

   dct_state_t       state, state_next;
   logic [DCT_W-1:0] acc, acc_next;
   logic [CNT_W-1:0] acc_cnt, acc_cnt_next;
   logic             free;
   logic             accept;
   logic             load;
   logic [DCT_W-1:0] load_buf;
   logic [CNT_W-1:0] load_cnt;
   logic             ending_next;
   logic             ended_next;

   // The output register can take a new word if empty or being consumed now.
   assign free      = !dct_valid || dct_ready;
   assign atm_ready = !reset && (state == FILL) && ((acc_cnt < LAST_SLOT) || free);
   assign accept    = atm_valid && atm_ready;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path infers a latch.
      state_next   = state;
      acc_next     = acc;
      acc_cnt_next = acc_cnt;
      load         = 1'b0;
      load_buf     = '0;
      load_cnt     = '0;
      ending_next  = test_ending;
      ended_next   = test_has_ended;

      case (state)
         FILL: begin
            if (accept) begin
               if (acc_cnt == LAST_SLOT) begin
                  load         = 1'b1;
                  load_buf     = put_atom(acc, acc_cnt, atm_code);
                  load_cnt     = FULL_COUNT;
                  acc_next     = '0;
                  acc_cnt_next = '0;
               end else begin
                  acc_next     = put_atom(acc, acc_cnt, atm_code);
                  acc_cnt_next = acc_cnt + 1'b1;
               end
            end
            // A same-cycle atom is already folded into acc_next, so the flush sees it.
            if (test_ending_in) begin
               ending_next = 1'b1;
               state_next  = FLUSH;
            end
         end
         FLUSH: begin
            if (free) begin
               if (acc_cnt != '0) begin
                  load         = 1'b1;
                  load_buf     = acc;
                  load_cnt     = acc_cnt;
                  acc_next     = '0;
                  acc_cnt_next = '0;
               end
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (free) begin
               ended_next = 1'b1;
               state_next = ENDED;
            end
         end
         ENDED: begin
            state_next = ENDED;
         end
         default: begin
            state_next = FILL;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (reset) begin
         state          <= FILL;
         acc            <= '0;
         acc_cnt        <= '0;
         dct_valid      <= 1'b0;
         dct_buffer     <= '0;
         dct_count      <= '0;
         test_ending    <= 1'b0;
         test_has_ended <= 1'b0;
      end else begin
         state          <= state_next;
         acc            <= acc_next;
         acc_cnt        <= acc_cnt_next;
         test_ending    <= ending_next;
         test_has_ended <= ended_next;
         // A load only happens when free, so it may overwrite a word consumed this cycle.
         if (load) begin
            dct_valid  <= 1'b1;
            dct_buffer <= load_buf;
            dct_count  <= load_cnt;
         end else if (dct_valid && dct_ready) begin
            dct_valid  <= 1'b0;
            dct_buffer <= '0;
            dct_count  <= '0;
         end
      end
   end

endmodule

// File: tb/tb_testing_cpu_oci_dct_packer.sv
// Scoreboard bench for the OCI atom packer: a bench-side packing model pushes
// expected words, a negedge monitor pops and compares each consumed word.
`timescale 1ns/1ps
module tb_testing_cpu_oci_dct_packer;

   logic        clk = 1'b0;
   logic        reset;
   logic        atm_valid;
   logic [1:0]  atm_code;
   logic        atm_ready;
   logic        test_ending_in;
   logic        dct_ready;
   logic        dct_valid;
   logic [29:0] dct_buffer;
   logic [3:0]  dct_count;
   logic        test_ending;
   logic        test_has_ended;

   typedef struct packed {
      logic [29:0] data;
      logic [3:0]  cnt;
   } word_t;

   word_t       sb_q[$];
   word_t       exp_w;
   int          checks = 0;
   int          errors = 0;
   int          words_seen = 0;
   logic [29:0] m_acc;
   int          m_cnt;
   logic [29:0] last_buf;
   logic        stalled = 1'b0;
   logic [29:0] held_buf;
   logic [3:0]  held_cnt;

   testing_cpu_oci_dct_packer dut (
      .clk            (clk),
      .reset          (reset),
      .atm_valid      (atm_valid),
      .atm_code       (atm_code),
      .atm_ready      (atm_ready),
      .test_ending_in (test_ending_in),
      .dct_ready      (dct_ready),
      .dct_valid      (dct_valid),
      .dct_buffer     (dct_buffer),
      .dct_count      (dct_count),
      .test_ending    (test_ending),
      .test_has_ended (test_has_ended)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor: outputs sampled on the falling edge, inputs change just after the rising edge.
   always @(negedge clk) begin
      if (reset) begin
         stalled <= 1'b0;
      end else begin
         if (dct_valid) check("cnt_nonzero", 32'(dct_count != 4'd0), 32'd1);
         if (stalled && dct_valid) begin
            check("hold_buf", 32'(dct_buffer), 32'(held_buf));
            check("hold_cnt", 32'(dct_count), 32'(held_cnt));
         end
         if (dct_valid && dct_ready) begin
            words_seen <= words_seen + 1;
            last_buf   <= dct_buffer;
            if (sb_q.size() == 0) begin
               check("unexpected_word", 32'(dct_buffer), 32'hFFFF_FFFF);
            end else begin
               exp_w = sb_q.pop_front();
               check("word_data", 32'(dct_buffer), 32'(exp_w.data));
               check("word_cnt", 32'(dct_count), 32'(exp_w.cnt));
            end
         end
         stalled  <= dct_valid && !dct_ready;
         held_buf <= dct_buffer;
         held_cnt <= dct_count;
      end
   end

   task automatic model_accept(input logic [1:0] c);
      m_acc = m_acc | (30'(c) << (2 * m_cnt));
      m_cnt++;
      if (m_cnt == 15) begin
         sb_q.push_back('{data: m_acc, cnt: 4'd15});
         m_acc = '0;
         m_cnt = 0;
      end
   endtask

   task automatic model_flush();
      if (m_cnt != 0) sb_q.push_back('{data: m_acc, cnt: 4'(m_cnt)});
      m_acc = '0;
      m_cnt = 0;
   endtask

   task automatic do_reset();
      reset          = 1'b1;
      atm_valid      = 1'b0;
      atm_code       = 2'b00;
      test_ending_in = 1'b0;
      dct_ready      = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_valid", 32'(dct_valid), 32'd0);
      check("rst_buf", 32'(dct_buffer), 32'd0);
      check("rst_cnt", 32'(dct_count), 32'd0);
      check("rst_ending", 32'(test_ending), 32'd0);
      check("rst_ended", 32'(test_has_ended), 32'd0);
      check("rst_atm_ready", 32'(atm_ready), 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      sb_q.delete();
      m_acc = '0;
      m_cnt = 0;
   endtask

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send_atom(input logic [1:0] c);
      int n;
      n         = 0;
      atm_valid = 1'b1;
      atm_code  = c;
      while (1) begin
         @(negedge clk);
         if (atm_ready) begin
            @(posedge clk);
            #1;
            atm_valid = 1'b0;
            model_accept(c);
            return;
         end
         n++;
         if (n > 100) begin
            check("atm_ready_timeout", 32'd0, 32'd1);
            atm_valid = 1'b0;
            return;
         end
      end
   endtask

   task automatic pulse_ending();
      test_ending_in = 1'b1;
      @(posedge clk);
      #1;
      test_ending_in = 1'b0;
      model_flush();
   endtask

   task automatic wait_ended(input int limit, output int cyc);
      cyc = 0;
      while (1) begin
         @(negedge clk);
         if (test_has_ended) return;
         cyc++;
         if (cyc > limit) begin
            check("ended_timeout", 32'(cyc), 32'(limit));
            return;
         end
      end
   endtask

   initial begin
      int cyc;
      int w0;

      // Full word, back-to-back, consumer always ready.
      do_reset();
      for (int i = 0; i < 15; i++) send_atom(2'b01);
      @(negedge clk);
      @(posedge clk);
      #1;
      check("full_literal", 32'(last_buf), 32'h1555_5555);
      check("full_words", 32'(words_seen), 32'd1);
      check("full_valid_off", 32'(dct_valid), 32'd0);
      check("full_sb_empty", 32'(sb_q.size()), 32'd0);

      // Backpressure: 30 atoms of 2'b10 with the consumer stalled.
      do_reset();
      w0        = words_seen;
      dct_ready = 1'b0;
      for (int i = 0; i < 29; i++) send_atom(2'b10);
      atm_valid = 1'b1;
      atm_code  = 2'b10;
      repeat (3) begin
         @(negedge clk);
         check("bp_ready_low", 32'(atm_ready), 32'd0);
         check("bp_hold_valid", 32'(dct_valid), 32'd1);
         check("bp_hold_buf", 32'(dct_buffer), 32'h2AAA_AAAA);
         check("bp_hold_cnt", 32'(dct_count), 32'd15);
      end
      @(posedge clk);
      #1;
      dct_ready = 1'b1;
      @(negedge clk);
      check("bp_ready_high", 32'(atm_ready), 32'd1);
      @(posedge clk);
      #1;
      atm_valid = 1'b0;
      model_accept(2'b10);
      check("bp_word1", 32'(last_buf), 32'h2AAA_AAAA);
      @(negedge clk);
      check("bp_no_bubble", 32'(dct_valid), 32'd1);
      @(posedge clk);
      #1;
      check("bp_words", 32'(words_seen - w0), 32'd2);
      check("bp_sb_empty", 32'(sb_q.size()), 32'd0);

      // Partial flush of atoms 3,2,1.
      do_reset();
      send_atom(2'b11);
      send_atom(2'b10);
      send_atom(2'b01);
      check("pf_model", 32'(sb_q.size()), 32'd0);
      pulse_ending();
      check("pf_ending", 32'(test_ending), 32'd1);
      wait_ended(10, cyc);
      @(posedge clk);
      #1;
      check("pf_literal", 32'(last_buf), 32'h0000_001B);
      atm_valid      = 1'b1;
      test_ending_in = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("pf_ended_sticky", 32'(test_has_ended), 32'd1);
         check("pf_ending_sticky", 32'(test_ending), 32'd1);
         check("pf_atm_ready", 32'(atm_ready), 32'd0);
         check("pf_no_valid", 32'(dct_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      atm_valid      = 1'b0;
      test_ending_in = 1'b0;
      check("pf_sb_empty", 32'(sb_q.size()), 32'd0);

      // Empty flush right after reset.
      do_reset();
      w0 = words_seen;
      pulse_ending();
      wait_ended(3, cyc);
      check("ef_latency_ok", 32'(cyc <= 2), 32'd1);
      check("ef_ended", 32'(test_has_ended), 32'd1);
      check("ef_no_word", 32'(words_seen - w0), 32'd0);

      // 15th atom and end-of-test in the same cycle.
      do_reset();
      w0 = words_seen;
      for (int i = 0; i < 14; i++) send_atom(2'b01);
      atm_valid      = 1'b1;
      atm_code       = 2'b11;
      test_ending_in = 1'b1;
      @(negedge clk);
      check("sim_ready", 32'(atm_ready), 32'd1);
      @(posedge clk);
      #1;
      atm_valid      = 1'b0;
      test_ending_in = 1'b0;
      model_accept(2'b11);
      model_flush();
      wait_ended(10, cyc);
      repeat (2) @(negedge clk);
      check("sim_words", 32'(words_seen - w0), 32'd1);
      check("sim_literal", 32'(last_buf), 32'h3555_5555);
      check("sim_ended", 32'(test_has_ended), 32'd1);
      check("sim_sb_empty", 32'(sb_q.size()), 32'd0);

      // Reset mid-fill discards the partial accumulator.
      do_reset();
      for (int i = 0; i < 7; i++) send_atom(2'b01);
      do_reset();
      w0 = words_seen;
      for (int i = 0; i < 15; i++) send_atom(2'b11);
      @(negedge clk);
      @(posedge clk);
      #1;
      check("rm_literal", 32'(last_buf), 32'h3FFF_FFFF);
      check("rm_words", 32'(words_seen - w0), 32'd1);
      check("rm_sb_empty", 32'(sb_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/testing_cpu_oci_dct_packer.md
Name: testing_cpu_oci_dct_packer

Overview:
- Packs 2-bit data-trace atoms from the OCI trace path into 30-bit words of 15 slots.
- Presents each word with a valid-atom count to the downstream OCI test-bench/trace consumer on the dct_buffer / dct_count / test_ending / test_has_ended interface.
- On an end-of-test request, flushes any partial word and then raises a sticky completion flag.

Parameters:
- ATOM_W, 2: bits per trace atom.
- SLOTS, 15: atoms per word. Buffer width is ATOM_W*SLOTS = 30; count width is 4.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- atm_valid  in  1  atom present.
- atm_code  in  2  atom value.
- atm_ready  out  1  atom accepted on a cycle where atm_valid && atm_ready.
- test_ending_in  in  1  end-of-test request; a one-cycle pulse is sufficient.
- dct_ready  in  1  consumer accepts the word on a cycle where dct_valid && dct_ready.
- dct_valid  out  1  output word valid.
- dct_buffer  out  30  packed word; slot k occupies bits [2k+1:2k], slot 0 is the oldest atom.
- dct_count  out  4  number of valid slots, 1..15.
- test_ending  out  1  sticky; flush requested.
- test_has_ended  out  1  sticky; flush complete, all data delivered.

Behaviour:
- Interface is decided: one clock, synchronous active-high reset; clock and reset ports are named clk and reset.
- Reset values:
  - dct_buffer=0, dct_count=0, dct_valid=0, test_ending=0, test_has_ended=0.
  - Accumulator and its count acc_cnt=0; state=FILL.
  - atm_ready is forced 0 while reset is high.
- Internal state: accumulator acc[29:0] and acc_cnt[3:0], plus an output register (dct_buffer/dct_count/dct_valid).
- States:
  - FILL: normal packing.
  - FLUSH: waiting for the output register to free up.
  - DRAIN: waiting for the flushed word to be consumed.
  - ENDED: terminal.
- Output register is "free" when dct_valid=0 or (dct_valid && dct_ready) in the same cycle.
- atm_ready = (state==FILL) && (acc_cnt<SLOTS-1 || free). It is combinational.
- Accepted atom, acc_cnt<14: write it to slot acc_cnt; acc_cnt+1.
- Accepted atom, acc_cnt==14:
  - Load the output register with acc plus this atom in slot 14; dct_count=15; dct_valid=1 on the next cycle (latency 1).
  - Clear the accumulator: acc=0, acc_cnt=0.
- Output register clears (dct_valid=0, dct_buffer=0, dct_count=0) on consume when no new load occurs that cycle. Consume and load in the same cycle means the new word replaces the old one with no bubble.
- While dct_valid && !dct_ready, dct_buffer and dct_count are held stable.
- test_ending_in seen in FILL:
  - test_ending <= 1; go to FLUSH.
  - An atom accepted in the same cycle is included in the flush.
  - If that atom completes a word, the full word loads normally and the flush then finds acc_cnt=0.
- FLUSH, when free:
  - acc_cnt>0: load the partial word (unused slots zero, dct_count=acc_cnt), clear the accumulator, go to DRAIN.
  - acc_cnt==0: no load; go to DRAIN.
- DRAIN: when dct_valid==0 (or is consumed this cycle), set test_has_ended <= 1 and go to ENDED.
- ENDED: atm_ready=0; test_ending_in is ignored. Only reset leaves ENDED.
- test_ending_in pulses outside FILL are ignored.
- Reset mid-operation discards partial and held data with no emission.
- dct_count is never 0 while dct_valid=1.

Decomposition:
- Shared package testing_cpu_oci_pkg:
  - ATOM_W, SLOTS, DCT_W=30, CNT_W=4.
  - State encoding: FILL=2'd0, FLUSH=2'd1, DRAIN=2'd2, ENDED=2'd3.
- No sub-module: the accumulator and output register are single always blocks, and the FSM is inline.

Test Plan:
- Full word: reset, then 15 atoms of code 2'b01 back-to-back with dct_ready=1 → one-cycle dct_valid after the 15th accept, dct_buffer=30'h15555555, dct_count=15.
- Backpressure: dct_ready=0, offer 30 atoms of code 2'b10.
  - First word holds at 30'h2AAAAAAA / 15.
  - atm_ready drops with acc_cnt=14 after 29 accepts.
  - Raising dct_ready consumes word 1 and accepts atom 30 in the same cycle; word 2 follows the next cycle.
- Partial flush: atoms 3,2,1 then a test_ending_in pulse → test_ending=1, dct_buffer=30'h0000001B, dct_count=3. After the consume, test_has_ended=1 and stays 1; atm_ready=0.
- Empty flush: test_ending_in right after reset → no dct_valid; test_has_ended=1 within 2 cycles.
- Simultaneous: 15th atom and test_ending_in in the same cycle → exactly one word with dct_count=15, no partial word, then test_has_ended.
- Reset mid-fill: 7 atoms accepted, reset pulse, then 15 atoms of code 2'b11 → single word 30'h3FFFFFFF / 15, with no residue from the earlier 7.
